// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_queue_pkg;

  localparam logic [5:0]  OPC_J   = 6'b000010;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fq_entry_t;

  // J-format target: upper nibble of the incremented PC, 26-bit word index, word aligned.
  function automatic logic [31:0] jumpTarget(input logic [31:0] pcPlus4,
                                             input logic [31:0] instr);
    return {pcPlus4[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// Circular {instruction, PC} buffer with push, pop and flush; head entry held in registers.
module fetch_queue_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rstN_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fq_entry_t              pushData_i,
  input  logic                   pop_i,
  output logic                   headValid_o,
  output fq_entry_t              headData_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fq_entry_t     mem_q [DEPTH];
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [CW-1:0] count_q, count_d;
  fq_entry_t     head_q, head_d;
  logic          headValid_q, headValid_d;
  logic          pushEn, popEn;

  always_comb begin
    popEn       = pop_i && !flush_i && (count_q != '0);
    pushEn      = push_i && !flush_i && ((count_q != CW'(DEPTH)) || popEn);
    rdPtr_d     = rdPtr_q;
    wrPtr_d     = wrPtr_q;
    count_d     = count_q;
    if (flush_i) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (pushEn) wrPtr_d = wrPtr_q + PW'(1);
      if (popEn)  rdPtr_d = rdPtr_q + PW'(1);
      count_d = count_q + CW'(pushEn) - CW'(popEn);
    end

    // The new head comes straight from the write port when it lands in the slot being exposed.
    headValid_d = (count_d != '0);
    head_d      = '0;
    if (headValid_d) begin
      if (pushEn && (wrPtr_q == rdPtr_d)) head_d = pushData_i;
      else                                head_d = mem_q[rdPtr_d];
    end
  end

  always_ff @(negedge clk_i) begin
    if (pushEn) mem_q[wrPtr_q] <= pushData_i;
  end

  always_ff @(negedge clk_i) begin
    if (!rstN_i) begin
      rdPtr_q     <= '0;
      wrPtr_q     <= '0;
      count_q     <= '0;
      head_q      <= '0;
      headValid_q <= 1'b0;
    end else begin
      rdPtr_q     <= rdPtr_d;
      wrPtr_q     <= wrPtr_d;
      count_q     <= count_d;
      head_q      <= head_d;
      headValid_q <= headValid_d;
    end
  end

  assign headValid_o = headValid_q;
  assign headData_o  = head_q;
  assign count_o     = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue top: request issue, credit, redirect drop accounting and optional J predecode.
// Optional feature: FETCH_QUEUE_PREDECODE_JUMP_EN redirects fetch on J opcodes at response time.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic            CLK,
  input  logic            Reset_L,
  input  logic [PC_W-1:0] startPC,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirectPC,
  output logic            imemReq,
  output logic [PC_W-1:0] imemAddr,
  input  logic            imemValid,
  input  logic [31:0]     imemRdata,
  input  logic            IFWrite,
  output logic            instrValid,
  output logic [31:0]     instrOut,
  output logic [PC_W-1:0] pcOut
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

  logic [PC_W-1:0] fetchPC_q, fetchPC_d;
  logic [PC_W-1:0] respPC_q, respPC_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   count;
  logic [CW:0]     used;
  logic            issue, respAccept, store, pop;
  fq_entry_t       pushData, headData;
`ifdef FETCH_QUEUE_PREDECODE_JUMP_EN
  logic            jumpHit;
  logic [31:0]     jumpPC;
`endif

  // Credit covers both stored entries and responses still on their way back.
  assign used       = (CW+1)'(count) + (CW+1)'(inflight_q);
  assign issue      = Reset_L && !redirect && (used < (CW+1)'(DEPTH));
  assign respAccept = imemValid && (inflight_q != '0);
  assign store      = respAccept && (drop_q == '0) && !redirect;
  assign pop        = instrValid && IFWrite && !redirect;
  assign pushData   = '{instr: imemRdata, pc: respPC_q};

  assign imemReq    = issue;
  assign imemAddr   = Reset_L ? fetchPC_q : startPC;
  assign inflight_d = inflight_q + CW'(issue) - CW'(respAccept);

`ifdef FETCH_QUEUE_PREDECODE_JUMP_EN
  assign jumpHit = store && (imemRdata[31:26] == OPC_J);
  assign jumpPC  = jumpTarget(respPC_q + STEP, imemRdata);
`endif

  // Every response still outstanding after a redirect or jump belongs to the old path.
  always_comb begin
    fetchPC_d = fetchPC_q;
    respPC_d  = respPC_q;
    drop_d    = drop_q;
    if (redirect) begin
      fetchPC_d = redirectPC;
      respPC_d  = redirectPC;
      drop_d    = inflight_d;
    end else begin
      if (issue) fetchPC_d = fetchPC_q + STEP;
      if (store) respPC_d  = respPC_q + STEP;
      if (respAccept && (drop_q != '0)) drop_d = drop_q - CW'(1);
`ifdef FETCH_QUEUE_PREDECODE_JUMP_EN
      if (jumpHit) begin
        fetchPC_d = jumpPC;
        respPC_d  = jumpPC;
        drop_d    = inflight_d;
      end
`endif
    end
  end

  always_ff @(negedge CLK) begin
    if (!Reset_L) begin
      fetchPC_q  <= startPC;
      respPC_q   <= startPC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fetchPC_q  <= fetchPC_d;
      respPC_q   <= respPC_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  fetch_queue_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (CLK),
    .rstN_i      (Reset_L),
    .flush_i     (redirect),
    .push_i      (store),
    .pushData_i  (pushData),
    .pop_i       (pop),
    .headValid_o (instrValid),
    .headData_o  (headData),
    .count_o     (count)
  );

  assign instrOut = headData.instr;
  assign pcOut    = headData.pc;

endmodule
